alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//   Parametrised, registered successor to the 8-bit combinational ALU. Accepts one
//   operation per valid/ready handshake and returns a registered result with true
//   Z/N/C/V flags. Shifts take a variable shift amount and run iteratively,
//   one bit per cycle. Sits between the register-file read stage and writeback.
// PARAMETERS
//   WIDTH    8   operand and result width in bits; must be >= 4.
//   SHW      $clog2(WIDTH)   width of the shift-amount field taken from b[SHW-1:0].
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operands and opcode are valid
//   in_ready   out  1      block can accept an operation; 1 only in IDLE
//   op         in   4      opcode (see BEHAVIOUR)
//   a, b       in   WIDTH  operands
//   out_valid  out  1      result and flags are valid
//   out_ready  in   1      consumer takes the result
//   out        out  WIDTH  result
//   z, n, c, v out  1      zero, negative (out[WIDTH-1]), carry/borrow, signed overflow
// BEHAVIOUR
//   - Reset: state=IDLE; in_ready=1; out_valid=0; out, z, n, c and v all 0.
//     Reset mid-operation discards the operation. No result is produced for it.
//   - FSM: IDLE -> (in_valid&&in_ready) -> EXEC -> DONE -> (out_ready) -> IDLE.
//     EXEC lasts 1 cycle for single-cycle ops, or N cycles for iterative ops.
//   - Accept: a, b and op are captured on the accept edge. Inputs are ignored
//     while in EXEC or DONE.
//   - DONE: out_valid=1. out and flags hold stable until out_ready=1. The return
//     to IDLE happens on that edge. No accept can occur in the same cycle; the
//     minimum issue interval is 3 cycles.
//   - Opcodes:
//     - 0 ADD: {c,out}=a+b. v is set when a and b have equal sign and out has a
//       different sign.
//     - 1 SUB: out=a-b. c=1 when a<b unsigned (borrow). v is set when a and b have
//       different signs and out's sign differs from a.
//     - 2 AND, 3 OR, 5 XOR: bitwise. c=0, v=0.
//     - 4 NOT: out=~a. c=0, v=0.
//     - 6 SHL, 7 SHR (logical): shift a by sh=b[SHW-1:0], one bit per EXEC cycle.
//       c is the last bit shifted out, and 0 if sh=0. v=0.
//       EXEC lasts max(sh,1) cycles.
//     - 8 MUL: see CONFIGURATION.
//     - 9-15 are reserved. They execute as ADD. No error flag is raised.
//   - Latency from the accept edge to out_valid: 2 cycles for single-cycle ops and
//     for shifts with sh<=1; sh+1 cycles for shifts with sh>1.
//   - Flags: z=(out==0) and n=out[WIDTH-1] for every op. All flags update only
//     when entering DONE.
//   - Width: all arithmetic is modulo 2^WIDTH. Internal sums are WIDTH+1 bits wide.
// CONFIGURATION
//   ALU_SEQ_MUL_EN defined: op 8 is an unsigned shift-add multiply.
//     - EXEC lasts WIDTH cycles.
//     - out = low WIDTH bits of a*b.
//     - c = v = (high WIDTH bits != 0).
//   ALU_SEQ_MUL_EN undefined: op 8 behaves as reserved (executes as ADD). No
//   multiplier hardware is built.
// STRUCTURE
//   alu_pkg:
//     - opcode localparams OP_ADD..OP_MUL
//     - state encoding ST_IDLE/ST_EXEC/ST_DONE
//     - flag bit indices
//   alu_iter_unit (sub-module):
//     - iterative shift/multiply datapath with a cycle counter and a done pulse
//     - the top owns the FSM, handshake, single-cycle ops and the flag registers
// TESTING
//   1 Reset with rst_n=0 mid-shift (op 6, sh=5) -> out_valid=0, in_ready=1 and
//     all outputs 0 immediately, before the next clock edge.
//   2 WIDTH=8: ADD 0x7F+0x01 -> out=0x80 n=1 v=1 c=0 z=0;
//     ADD 0xFF+0x01 -> out=0x00 z=1 c=1 v=0.
//   3 WIDTH=8: SUB 0x03-0x05 -> out=0xFE c=1 n=1 v=0;
//     SUB 0x80-0x01 -> out=0x7F v=1.
//   4 WIDTH=8: SHL a=0x81 sh=3 -> out=0x08 c=0 after 4 cycles;
//     SHR a=0x81 sh=1 -> out=0x40 c=1; sh=0 -> out=a c=0 at 2 cycles.
//   5 Backpressure: hold out_ready=0 for 5 cycles -> out and flags stable, in_ready=0,
//     new in_valid ignored; release -> IDLE next cycle.
//   6 ALU_SEQ_MUL_EN, WIDTH=8: MUL 0x10*0x10 -> out=0x00 z=1 c=v=1 after 9 cycles.
//     Macro undefined: op 8 with the same operands -> out=0x20, as ADD.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states, flag indices and opcode canonicalisation for alu_seq.
// ALU_SEQ_MUL_EN enables opcode 8 as a multiply; otherwise it folds to ADD.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    IT_SHL = 2'd0,
    IT_SHR = 2'd1,
    IT_MUL = 2'd2
  } iter_mode_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  // Reserved opcodes (and MUL when not built) are mapped to ADD at accept time.
  function automatic logic [3:0] canon_op(input logic [3:0] op);
    if (op > OP_MUL) return OP_ADD;
`ifndef ALU_SEQ_MUL_EN
    if (op == OP_MUL) return OP_ADD;
`endif
    return op;
  endfunction

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: one-bit-per-cycle shifts and (with ALU_SEQ_MUL_EN) a shift-add multiply.
// Outputs show the value after the current cycle's step so the caller can latch on done.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             busy,
  input  iter_mode_t       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             c,
  output logic             v,
  output logic             done
);

  localparam int CW = SHW + 1;

  iter_mode_t       mode_reg;
  logic [WIDTH-1:0] val_reg;
  logic [WIDTH-1:0] val_step;
  logic             carry_reg;
  logic             carry_step;
  logic [CW-1:0]    cnt_reg;

`ifdef ALU_SEQ_MUL_EN
  // val_reg holds the multiplier and fills with low product bits as it shifts right.
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] hi_step;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH:0]   psum;
`else
  logic unused_b;
  assign unused_b = ^b[WIDTH-1:SHW];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg  <= IT_SHL;
      val_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
`ifdef ALU_SEQ_MUL_EN
      hi_reg    <= '0;
      mcand_reg <= '0;
`endif
    end else if (start) begin
      mode_reg  <= mode;
      val_reg   <= a;
      carry_reg <= 1'b0;
      cnt_reg   <= (mode == IT_MUL) ? CW'(WIDTH) : CW'(b[SHW-1:0]);
`ifdef ALU_SEQ_MUL_EN
      hi_reg    <= '0;
      mcand_reg <= b;
`endif
    end else if (busy && (cnt_reg != '0)) begin
      val_reg   <= val_step;
      carry_reg <= carry_step;
      cnt_reg   <= cnt_reg - CW'(1);
`ifdef ALU_SEQ_MUL_EN
      hi_reg    <= hi_step;
`endif
    end
  end

  always_comb begin
    val_step   = val_reg;
    carry_step = carry_reg;
`ifdef ALU_SEQ_MUL_EN
    psum       = '0;
    hi_step    = hi_reg;
`endif
    if (cnt_reg != '0) begin
      case (mode_reg)
        IT_SHL: begin
          val_step   = {val_reg[WIDTH-2:0], 1'b0};
          carry_step = val_reg[WIDTH-1];
        end
        IT_SHR: begin
          val_step   = {1'b0, val_reg[WIDTH-1:1]};
          carry_step = val_reg[0];
        end
        default: begin
`ifdef ALU_SEQ_MUL_EN
          psum     = {1'b0, hi_reg} + (val_reg[0] ? {1'b0, mcand_reg} : '0);
          hi_step  = psum[WIDTH:1];
          val_step = {psum[0], val_reg[WIDTH-1:1]};
`endif
        end
      endcase
    end
  end

  assign res  = val_step;
  assign done = busy && (cnt_reg <= CW'(1));

`ifdef ALU_SEQ_MUL_EN
  assign c = (mode_reg == IT_MUL) ? (hi_step != '0) : carry_step;
  assign v = (mode_reg == IT_MUL) && (hi_step != '0);
`else
  assign c = carry_step;
  assign v = 1'b0;
`endif

endmodule

// File: rtl/alu_seq.sv
// Registered handshake ALU with Z/N/C/V flags; shifts (and MUL when ALU_SEQ_MUL_EN
// is defined) run iteratively in alu_iter_unit, everything else takes one EXEC cycle.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v
);

  state_t           state_reg;
  state_t           state_next;
  logic [3:0]       op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] out_reg;
  logic [3:0]       flags_reg;

  logic [3:0]       op_in;
  logic             accept;
  logic             exec_done;
  logic             iter_busy;
  logic             iter_done;
  logic             iter_c;
  logic             iter_v;
  logic [WIDTH-1:0] iter_res;
  iter_mode_t       iter_mode;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res_next;
  logic             c_next;
  logic             v_next;

  assign op_in     = canon_op(op);
  assign accept    = (state_reg == ST_IDLE) && in_valid;
  assign iter_busy = (state_reg == ST_EXEC) && is_iter_op(op_reg);
  assign exec_done = is_iter_op(op_reg) ? iter_done : 1'b1;
  assign iter_mode = (op_in == OP_SHL) ? IT_SHL : (op_in == OP_SHR) ? IT_SHR : IT_MUL;

  alu_iter_unit #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && is_iter_op(op_in)),
    .busy  (iter_busy),
    .mode  (iter_mode),
    .a     (a),
    .b     (b),
    .res   (iter_res),
    .c     (iter_c),
    .v     (iter_v),
    .done  (iter_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      op_reg    <= OP_ADD;
      a_reg     <= '0;
      b_reg     <= '0;
      out_reg   <= '0;
      flags_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg <= op_in;
        a_reg  <= a;
        b_reg  <= b;
      end
      if ((state_reg == ST_EXEC) && exec_done) begin
        out_reg           <= res_next;
        flags_reg[FLAG_Z] <= (res_next == '0);
        flags_reg[FLAG_N] <= res_next[WIDTH-1];
        flags_reg[FLAG_C] <= c_next;
        flags_reg[FLAG_V] <= v_next;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (in_valid) state_next = ST_EXEC;
      ST_EXEC: if (exec_done) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign sum  = {1'b0, a_reg} + {1'b0, b_reg};
  assign diff = {1'b0, a_reg} - {1'b0, b_reg};

  // diff[WIDTH] is the borrow out of the unsigned subtraction.
  always_comb begin
    res_next = sum[WIDTH-1:0];
    c_next   = sum[WIDTH];
    v_next   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum[WIDTH-1] != a_reg[WIDTH-1]);
    case (op_reg)
      OP_SUB: begin
        res_next = diff[WIDTH-1:0];
        c_next   = diff[WIDTH];
        v_next   = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (diff[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_AND: begin
        res_next = a_reg & b_reg;
        c_next   = 1'b0;
        v_next   = 1'b0;
      end
      OP_OR: begin
        res_next = a_reg | b_reg;
        c_next   = 1'b0;
        v_next   = 1'b0;
      end
      OP_NOT: begin
        res_next = ~a_reg;
        c_next   = 1'b0;
        v_next   = 1'b0;
      end
      OP_XOR: begin
        res_next = a_reg ^ b_reg;
        c_next   = 1'b0;
        v_next   = 1'b0;
      end
      OP_SHL, OP_SHR, OP_MUL: begin
        res_next = iter_res;
        c_next   = iter_c;
        v_next   = iter_v;
      end
      default: ;
    endcase
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign out       = out_reg;
  assign z         = flags_reg[FLAG_Z];
  assign n         = flags_reg[FLAG_N];
  assign c         = flags_reg[FLAG_C];
  assign v         = flags_reg[FLAG_V];

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8): fixed vector table, backpressure and mid-shift reset
// sequences, then random operations checked against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out;
  logic         z, n, c, v;

  int total = 0;
  int bad = 0;

  typedef struct {
    int op;
    int a;
    int b;
    int out;
    int c;
    int v;
    int z;
    int n;
    int lat;
  } vec_t;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .z         (z),
    .n         (n),
    .c         (c),
    .v         (v)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int o, input int x, input int y, input int r,
                              input int cc, input int vv, input int zz, input int nn,
                              input int l);
    vec_t e;
    e.op = o; e.a = x; e.b = y; e.out = r; e.c = cc; e.v = vv; e.z = zz; e.n = nn; e.lat = l;
    return e;
  endfunction

  // Reference model: plain integer arithmetic on the opcode rules.
  function automatic vec_t model(input int o, input int x, input int y);
    int eo, r, cc, vv, sh, l, sx, sy, sr;
    longint p;
    eo = o;
    if (o > 8) eo = 0;
`ifndef ALU_SEQ_MUL_EN
    if (o == 8) eo = 0;
`endif
    sh = y % W;
    cc = 0; vv = 0; l = 2; r = 0;
    sx = (x >> (W-1)) & 1;
    sy = (y >> (W-1)) & 1;
    case (eo)
      0: begin
        r = (x + y) % 256;
        cc = (x + y >= 256) ? 1 : 0;
        sr = (r >> (W-1)) & 1;
        vv = (sx == sy && sr != sx) ? 1 : 0;
      end
      1: begin
        r = (x - y + 256) % 256;
        cc = (x < y) ? 1 : 0;
        sr = (r >> (W-1)) & 1;
        vv = (sx != sy && sr != sx) ? 1 : 0;
      end
      2: r = x & y;
      3: r = x | y;
      4: r = 255 - x;
      5: r = x ^ y;
      6: begin
        r = (x << sh) % 256;
        cc = (sh == 0) ? 0 : (x >> (W - sh)) & 1;
        l = ((sh > 1) ? sh : 1) + 1;
      end
      7: begin
        r = x >> sh;
        cc = (sh == 0) ? 0 : (x >> (sh - 1)) & 1;
        l = ((sh > 1) ? sh : 1) + 1;
      end
      default: begin
        p = longint'(x) * longint'(y);
        r = int'(p % 256);
        cc = (p >= 256) ? 1 : 0;
        vv = cc;
        l = W + 1;
      end
    endcase
    return mk(o, x, y, r, cc, vv, (r == 0) ? 1 : 0, (r >> (W-1)) & 1, l);
  endfunction

  task automatic run_op(input string tag, input vec_t e, input int hold);
    int lat;
    logic [W-1:0] o_s;
    logic [3:0] f_s;
    @(negedge clk);
    op = 4'(e.op); a = W'(e.a); b = W'(e.b); in_valid = 1'b1; out_ready = 1'b0;
    check({tag, " in_ready_at_issue"}, 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'($urandom); a = W'($urandom); b = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, e.lat);
    check({tag, " out"}, 32'(out), e.out);
    check({tag, " c"}, 32'(c), e.c);
    check({tag, " v"}, 32'(v), e.v);
    check({tag, " z"}, 32'(z), e.z);
    check({tag, " n"}, 32'(n), e.n);
    o_s = out;
    f_s = {z, n, c, v};
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'b1; op = 4'($urandom); a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      check({tag, " hold_out"}, 32'(out), 32'(o_s));
      check({tag, " hold_flags"}, 32'({z, n, c, v}), 32'(f_s));
      check({tag, " hold_valid"}, 32'(out_valid), 1);
      check({tag, " hold_in_ready"}, 32'(in_ready), 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " release_valid"}, 32'(out_valid), 0);
    check({tag, " release_in_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t e;
    int seen;

    tbl.push_back(mk(0, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 1, 2));
    tbl.push_back(mk(0, 8'hFF, 8'h01, 8'h00, 1, 0, 1, 0, 2));
    tbl.push_back(mk(1, 8'h03, 8'h05, 8'hFE, 1, 0, 0, 1, 2));
    tbl.push_back(mk(1, 8'h80, 8'h01, 8'h7F, 0, 1, 0, 0, 2));
    tbl.push_back(mk(2, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, 2));
    tbl.push_back(mk(3, 8'hF0, 8'h3C, 8'hFC, 0, 0, 0, 1, 2));
    tbl.push_back(mk(4, 8'h0F, 8'h00, 8'hF0, 0, 0, 0, 1, 2));
    tbl.push_back(mk(5, 8'hF0, 8'h3C, 8'hCC, 0, 0, 0, 1, 2));
    tbl.push_back(mk(6, 8'h81, 8'h03, 8'h08, 0, 0, 0, 0, 4));
    tbl.push_back(mk(7, 8'h81, 8'h01, 8'h40, 1, 0, 0, 0, 2));
    tbl.push_back(mk(7, 8'h81, 8'h00, 8'h81, 0, 0, 0, 1, 2));
    tbl.push_back(mk(6, 8'hFF, 8'h07, 8'h80, 1, 0, 0, 1, 8));
    tbl.push_back(mk(12, 8'hFF, 8'h01, 8'h00, 1, 0, 1, 0, 2));
`ifdef ALU_SEQ_MUL_EN
    tbl.push_back(mk(8, 8'h10, 8'h10, 8'h00, 1, 1, 1, 0, 9));
`else
    tbl.push_back(mk(8, 8'h10, 8'h10, 8'h20, 0, 0, 0, 0, 2));
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 1);
    check("reset out_valid", 32'(out_valid), 0);
    check("reset out", 32'(out), 0);
    check("reset flags", 32'({z, n, c, v}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) run_op($sformatf("vec%0d", i), tbl[i], 0);

    // Backpressure: result held for five cycles with new requests ignored.
    run_op("backpressure", mk(0, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 1, 2), 5);

    // Reset in the middle of a 5-bit shift, with a nonzero prior result on out.
    run_op("pre_reset", mk(2, 8'hFF, 8'hFF, 8'hFF, 0, 0, 0, 1, 2), 0);
    @(negedge clk);
    op = 4'd6; a = 8'hAB; b = 8'h05; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    check("midshift in_ready", 32'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    check("midshift_reset out_valid", 32'(out_valid), 0);
    check("midshift_reset in_ready", 32'(in_ready), 1);
    check("midshift_reset out", 32'(out), 0);
    check("midshift_reset flags", 32'({z, n, c, v}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midshift_reset no_result", seen, 0);

    // Random operations against the model.
    for (int k = 0; k < 150; k++) begin
      e = model($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255));
      run_op($sformatf("rand%0d op%0d a%0h b%0h", k, e.op, e.a, e.b), e, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
